// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants and fetch-state encoding for the SCRISC-16 instruction fetch unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instr_fetch_unit_pkg;

  localparam int          IFU_ADDR_W   = 16;
  localparam int          IFU_INSTR_W  = 16;
  localparam int          IFU_DEPTH    = 4;
  localparam logic [15:0] IFU_RESET_PC = 16'h0000;

  // IDLE: no request; REQ: request whose data will be kept;
  // DROP: request still outstanding whose data must be thrown away
  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_REQ  = 2'd1,
    FS_DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Prefetch FIFO holding {pc, instr} entries; flush empties it and dominates push.
// Latency: push at edge N is visible at the head in cycle N+1.
// Backpressure: push while full or pop while empty is ignored; the caller reserves space.
module instr_fetch_unit_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_nxt,
  output logic [W-1:0]  head_dat
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign do_pop    = pop && (count_q != '0) && !flush;
  assign do_push   = push && !flush && ((count_q != FULL_CNT) || do_pop);
  assign count     = count_q;
  assign count_nxt = count_d;
  assign head_dat  = mem_q[rd_ptr_q];

  // Next pointers and occupancy; a flush keeps the read pointer so the head value holds
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = rd_ptr_q;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage and pointer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= push_dat;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// SCRISC-16 fetch stage: req/ack fetches into a prefetch FIFO, valid/ready towards the datapath.
// Latency: imem_ack at edge N gives instr_valid in cycle N+1; 1 instr/cycle with single-cycle acks.
// Backpressure: a request is only issued with a FIFO slot reserved; redirect flushes and refetches.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = IFU_ADDR_W,
  parameter int                INSTR_W  = IFU_INSTR_W,
  parameter int                DEPTH    = IFU_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IFU_RESET_PC)
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc
);

  localparam int                CW         = $clog2(DEPTH + 1);
  localparam int                EW         = ADDR_W + INSTR_W;
  localparam logic [CW-1:0]     FULL_CNT   = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic              imem_req_q, imem_req_d;
  logic [CW-1:0]     count, count_nxt;
  logic              push, pop;
  logic [EW-1:0]     push_dat, head_dat;

  // Only an ack for a keepable request is pushed; redirect discards same-cycle data
  assign push     = (state_q == FS_REQ) && imem_ack && !redirect;
  assign pop      = instr_valid && instr_ready;
  assign push_dat = {fetch_pc_q, imem_rdata};

  assign instr_valid         = (count != '0);
  assign {instr_pc, instr}   = head_dat;
  assign imem_req            = imem_req_q;
  assign imem_addr           = imem_addr_q;

  instr_fetch_unit_fifo #(
    .W     (EW),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_dat  (push_dat),
    .pop       (pop),
    .flush     (redirect),
    .count     (count),
    .count_nxt (count_nxt),
    .head_dat  (head_dat)
  );

  // Next fetch PC, state and registered request outputs
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc & ALIGN_MASK;
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end

    case (state_q)
      FS_IDLE: begin
        // a redirect flushes, so count_nxt is zero and fetch restarts
        if (count_nxt < FULL_CNT) state_d = FS_REQ;
      end
      FS_REQ: begin
        if (redirect) begin
          state_d = imem_ack ? FS_REQ : FS_DROP;
        end else if (imem_ack) begin
          // only keep requesting while the next entry has a guaranteed slot
          state_d = (count_nxt < FULL_CNT) ? FS_REQ : FS_IDLE;
        end
      end
      FS_DROP: begin
        // the stale request completes; the FIFO is empty so a slot is free
        if (imem_ack) state_d = FS_REQ;
      end
      default: state_d = FS_IDLE;
    endcase

    imem_req_d  = (state_d != FS_IDLE);
    // the memory must see a stable address until the stale request is acked
    imem_addr_d = (state_d == FS_DROP) ? imem_addr_q : fetch_pc_d;
  end

  // Fetch state, PC and the memory-side output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FS_IDLE;
      fetch_pc_q  <= RESET_PC;
      imem_req_q  <= 1'b0;
      imem_addr_q <= RESET_PC;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: cycle table for start-up and wrap, scoreboard of popped instructions.
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  // main DUT (RESET_PC = 0)
  logic        imem_req, imem_ack, instr_valid, instr_ready, redirect;
  logic [15:0] imem_addr, imem_rdata, instr, instr_pc, redirect_pc;
  // wrap DUT (RESET_PC = FFFC), always ready, memory acks in one cycle
  logic        imem_req_w, imem_ack_w, instr_valid_w, instr_ready_w, redirect_w;
  logic [15:0] imem_addr_w, imem_rdata_w, instr_w, instr_pc_w, redirect_pc_w;

  // memory model controls
  int   mem_lat;
  logic mem_en;
  logic ack_force;
  int   wait_cnt;

  int checks;
  int failures;
  int pops;
  int acks;
  logic [15:0] exp_q [$];

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  instr_fetch_unit u_dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  instr_fetch_unit #(.RESET_PC(16'hFFFC)) u_dut_w (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req_w),
    .imem_addr   (imem_addr_w),
    .imem_ack    (imem_ack_w),
    .imem_rdata  (imem_rdata_w),
    .instr_valid (instr_valid_w),
    .instr       (instr_w),
    .instr_pc    (instr_pc_w),
    .instr_ready (instr_ready_w),
    .redirect    (redirect_w),
    .redirect_pc (redirect_pc_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory models: ack after mem_lat cycles of a held request
  always @(posedge clk) begin
    if (reset || imem_ack) wait_cnt <= 0;
    else if (imem_req)     wait_cnt <= wait_cnt + 1;
  end
  assign imem_ack     = ack_force | (mem_en & imem_req & (wait_cnt >= mem_lat - 1));
  assign imem_rdata   = mem_fn(imem_addr);
  assign imem_ack_w   = imem_req_w;
  assign imem_rdata_w = mem_fn(imem_addr_w);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // negedge observation: scoreboard pops and ack counting
  task automatic monitor();
    logic [15:0] e;
    if (imem_req && imem_ack) acks++;
    if (instr_valid && instr_ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got pc %h expected no instruction", instr_pc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", {16'h0, instr_pc}, {16'h0, e});
        chk("sb_instr", {16'h0, instr}, {16'h0, mem_fn(e)});
      end
    end
  endtask

  // one clock: observe at negedge, return 1 time unit after the next rising edge
  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic load_q(input logic [15:0] base);
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(base + 16'(2 * i));
  endtask

  task automatic wait_pops(input int n, input string name);
    int p0;
    int i;
    p0 = pops;
    i = 0;
    while ((pops - p0 < n) && (i < 60)) begin
      step();
      i++;
    end
    chk(name, {31'h0, (pops - p0 >= n)}, 32'h1);
  endtask

  // leaves reset asserted across two edges; caller releases it
  task automatic do_reset();
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    ack_force   = 1'b0;
    mem_en      = 1'b1;
    mem_lat     = 1;
    step();
    step();
    exp_q.delete();
  endtask

  typedef struct {
    logic        rdy;
    logic        exp_req;
    logic [15:0] exp_addr;
    logic        exp_vld;
    logic [15:0] exp_pc;
    logic [15:0] exp_addr_w;
    logic [15:0] exp_pc_w;
  } vec_t;

  vec_t vec [6];

  initial begin
    logic        found;
    logic [15:0] e;
    int          a0;

    checks        = 0;
    failures      = 0;
    pops          = 0;
    acks          = 0;
    instr_ready   = 1'b0;
    instr_ready_w = 1'b1;
    redirect_w    = 1'b0;
    redirect_pc_w = 16'h0000;

    // per cycle after reset release, single-cycle memory, consumer always ready
    vec[0] = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'hFFFC, 16'h0000};
    vec[1] = '{1'b1, 1'b1, 16'h0002, 1'b1, 16'h0000, 16'hFFFE, 16'hFFFC};
    vec[2] = '{1'b1, 1'b1, 16'h0004, 1'b1, 16'h0002, 16'h0000, 16'hFFFE};
    vec[3] = '{1'b1, 1'b1, 16'h0006, 1'b1, 16'h0004, 16'h0002, 16'h0000};
    vec[4] = '{1'b1, 1'b1, 16'h0008, 1'b1, 16'h0006, 16'h0004, 16'h0002};
    vec[5] = '{1'b1, 1'b1, 16'h000A, 1'b1, 16'h0008, 16'h0006, 16'h0004};

    // ---- reset state, streaming start-up and address wrap ----
    instr_ready = 1'b1;
    do_reset();
    chk("rst_req",    {31'h0, imem_req},      32'h0);
    chk("rst_valid",  {31'h0, instr_valid},   32'h0);
    chk("rst_addr",   {16'h0, imem_addr},     32'h0000);
    chk("rst_req_w",  {31'h0, imem_req_w},    32'h0);
    chk("rst_addr_w", {16'h0, imem_addr_w},   32'hFFFC);
    chk("rst_vld_w",  {31'h0, instr_valid_w}, 32'h0);
    load_q(16'h0000);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      instr_ready = vec[i].rdy;
      step();
      chk("t1_req",   {31'h0, imem_req},    {31'h0, vec[i].exp_req});
      chk("t1_addr",  {16'h0, imem_addr},   {16'h0, vec[i].exp_addr});
      chk("t1_valid", {31'h0, instr_valid}, {31'h0, vec[i].exp_vld});
      if (vec[i].exp_vld) chk("t1_pc", {16'h0, instr_pc}, {16'h0, vec[i].exp_pc});
      chk("t5_addr_w",  {16'h0, imem_addr_w},   {16'h0, vec[i].exp_addr_w});
      chk("t5_valid_w", {31'h0, instr_valid_w}, {31'h0, vec[i].exp_vld});
      if (vec[i].exp_vld) begin
        chk("t5_pc_w",    {16'h0, instr_pc_w}, {16'h0, vec[i].exp_pc_w});
        chk("t5_instr_w", {16'h0, instr_w},    {16'h0, mem_fn(vec[i].exp_pc_w)});
      end
    end

    // ---- consumer stalled: exactly DEPTH acks, then resume at 8 ----
    instr_ready = 1'b0;
    do_reset();
    reset = 1'b0;
    a0 = acks;
    repeat (10) step();
    chk("t2_acks",  acks - a0,              32'd4);
    chk("t2_req",   {31'h0, imem_req},      32'h0);
    chk("t2_valid", {31'h0, instr_valid},   32'h1);
    chk("t2_head",  {16'h0, instr_pc},      32'h0000);
    load_q(16'h0000);
    instr_ready = 1'b1;
    step();
    chk("t2_resume_req",  {31'h0, imem_req}, 32'h1);
    chk("t2_resume_addr", {16'h0, imem_addr}, 32'h0008);
    wait_pops(6, "t2_drain");

    // ---- 3-cycle memory, redirect while request for 8 is outstanding ----
    instr_ready = 1'b1;
    do_reset();
    mem_lat = 3;
    load_q(16'h0000);
    reset = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (imem_req && imem_addr == 16'h0008) found = 1'b1;
    end
    chk("t3_req8_seen", {31'h0, found}, 32'h1);
    step();
    redirect    = 1'b1;
    redirect_pc = 16'h0101;
    load_q(16'h0100);
    step();
    redirect = 1'b0;
    chk("t3_drop_req",   {31'h0, imem_req},    32'h1);
    chk("t3_drop_addr",  {16'h0, imem_addr},   32'h0008);
    chk("t3_drop_valid", {31'h0, instr_valid}, 32'h0);
    step();
    chk("t3_new_req",  {31'h0, imem_req},  32'h1);
    chk("t3_new_addr", {16'h0, imem_addr}, 32'h0100);
    wait_pops(3, "t3_refetch");

    // ---- redirect in the same cycle as ack and pop ----
    instr_ready = 1'b1;
    do_reset();
    load_q(16'h0000);
    reset = 1'b0;
    repeat (4) step();
    chk("t4_pre_ack",   {31'h0, imem_ack},    32'h1);
    chk("t4_pre_valid", {31'h0, instr_valid}, 32'h1);
    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    e = exp_q[0];
    load_q(16'h0040);
    exp_q.push_front(e);
    step();
    redirect = 1'b0;
    chk("t4_valid", {31'h0, instr_valid}, 32'h0);
    chk("t4_req",   {31'h0, imem_req},    32'h1);
    chk("t4_addr",  {16'h0, imem_addr},   32'h0040);
    wait_pops(3, "t4_refetch");

    // ---- reset while in DROP with an ack pulse ----
    instr_ready = 1'b1;
    do_reset();
    mem_en = 1'b0;
    reset  = 1'b0;
    step();
    chk("t6_req0",  {31'h0, imem_req},  32'h1);
    chk("t6_addr0", {16'h0, imem_addr}, 32'h0000);
    redirect    = 1'b1;
    redirect_pc = 16'h0200;
    step();
    redirect = 1'b0;
    chk("t6_drop_req",  {31'h0, imem_req},  32'h1);
    chk("t6_drop_addr", {16'h0, imem_addr}, 32'h0000);
    reset     = 1'b1;
    ack_force = 1'b1;
    step();
    chk("t6_rst_req",   {31'h0, imem_req},    32'h0);
    chk("t6_rst_valid", {31'h0, instr_valid}, 32'h0);
    reset = 1'b0;
    step();
    ack_force = 1'b0;
    mem_en    = 1'b1;
    chk("t6_restart_req",   {31'h0, imem_req},    32'h1);
    chk("t6_restart_addr",  {16'h0, imem_addr},   32'h0000);
    chk("t6_restart_valid", {31'h0, instr_valid}, 32'h0);
    load_q(16'h0000);
    wait_pops(3, "t6_refetch");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
